// File: rtl/mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mult_issue_ctrl
// Upstream sequencer for the radix-4 iterative multiplier. Accepts operand
// pairs over valid/ready, drives the multiplier with a hold-high mult_begin,
// captures the product on mult_end into a single-entry result register and
// aborts with a zero product if mult_end does not arrive within TIMEOUT cycles.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              operand handshake (in_ready combinational)
//   in_op1, in_op2, in_tag         signed operands and request tag
//   mult_begin, mult_op1/2         multiplier request, held for whole operation
//   mult_product, mult_end         multiplier result and completion pulse
//   out_valid/out_ready            result handshake
//   out_product, out_tag           captured product (0 on timeout) and its tag
//   out_timeout                    result came from a timeout abort
//   busy                           an operation is in flight
// -----------------------------------------------------------------------------
module mult_issue_ctrl #(
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_op1,
   input  logic [31:0]       in_op2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              mult_begin,
   output logic [31:0]       mult_op1,
   output logic [31:0]       mult_op2,
   input  logic [63:0]       mult_product,
   input  logic              mult_end,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_product,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_timeout,
   output logic              busy
);

   localparam int unsigned OP_W   = 32;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]        state_q,       state_d;
   logic [CNT_W-1:0]  cnt_q,         cnt_d;
   logic              begin_q,       begin_d;
   logic [OP_W-1:0]   op1_q,         op1_d;
   logic [OP_W-1:0]   op2_q,         op2_d;
   logic [TAG_W-1:0]  tag_q,         tag_d;
   logic              out_valid_q,   out_valid_d;
   logic [PROD_W-1:0] out_product_q, out_product_d;
   logic [TAG_W-1:0]  out_tag_q,     out_tag_d;
   logic              out_timeout_q, out_timeout_d;
   logic              accept_c;

   // Issue only from IDLE, and only if the result slot is empty or draining now.
   assign in_ready = (state_q == S_IDLE) & (~out_valid_q | out_ready);
   assign accept_c = in_valid & in_ready;

   // State register and all datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         begin_q       <= 1'b0;
         op1_q         <= '0;
         op2_q         <= '0;
         tag_q         <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_tag_q     <= '0;
         out_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         begin_q       <= begin_d;
         op1_q         <= op1_d;
         op2_q         <= op2_d;
         tag_q         <= tag_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
         out_tag_q     <= out_tag_d;
         out_timeout_q <= out_timeout_d;
      end
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      begin_d       = begin_q;
      op1_d         = op1_q;
      op2_d         = op2_q;
      tag_d         = tag_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      out_tag_d     = out_tag_q;
      out_timeout_d = out_timeout_q;

      // Consumer drain; a same-cycle capture below overrides it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               op1_d   = in_op1;
               op2_d   = in_op2;
               tag_d   = in_tag;
               begin_d = 1'b1;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Completion wins over a coincident timeout.
            if (mult_end) begin
               out_product_d = mult_product;
               out_tag_d     = tag_q;
               out_timeout_d = 1'b0;
               out_valid_d   = 1'b1;
               begin_d       = 1'b0;
               state_d       = S_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               out_product_d = '0;
               out_tag_d     = tag_q;
               out_timeout_d = 1'b1;
               out_valid_d   = 1'b1;
               begin_d       = 1'b0;
               state_d       = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            begin_d = 1'b0;
         end
      endcase
   end

   assign mult_begin  = begin_q;
   assign mult_op1    = op1_q;
   assign mult_op2    = op2_q;
   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;
   assign out_tag     = out_tag_q;
   assign out_timeout = out_timeout_q;
   assign busy        = (state_q != S_IDLE);

endmodule
